// File: rtl/boruss_ram_arbiter.sv
// -----------------------------------------------------------------------------
// boruss_ram_arbiter
//
// Shares one single-port RAM between two requesters (A and B). Each access
// takes three cycles: arbitrate (IDLE), drive the RAM strobe (ISSUE), then
// capture read data and pulse done (CAPTURE). All outputs except busy are
// registered. busy is decoded directly from the state register.
//
// Parameters
//   FIXED_PRIORITY  0 = round-robin on contention, 1 = port A always wins
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request, access type, address, data
//   a_done/a_rdata             port A completion pulse and read data
//   b_*                        port B equivalents of the a_* ports
//   ram_address/ram_data_in    RAM address and write data
//   ram_write_enable           RAM write strobe (one cycle, ISSUE only)
//   ram_read_enable            RAM read strobe  (one cycle, ISSUE only)
//   ram_data_out               RAM read data, valid one cycle after the strobe
//   busy                       high while an access is in flight
// -----------------------------------------------------------------------------
module boruss_ram_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_done,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_done,
  output logic [7:0] b_rdata,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data_in,
  output logic       ram_write_enable,
  output logic       ram_read_enable,
  input  logic [7:0] ram_data_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state, state_nx;
  logic   prio;     // round-robin pointer: 0 = A wins contention, 1 = B wins
  logic   lat_id;   // latched winner: 0 = A, 1 = B
  logic   lat_we;   // latched access type of the winner
  logic   a_elig, b_elig, grant, grant_b;

  // A port whose done is high this cycle is still holding req from the access
  // just completed; masking it stops that stale req from being served twice.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    a_elig   = a_req && !a_done;
    b_elig   = b_req && !b_done;
    grant    = a_elig || b_elig;
    grant_b  = b_elig && (!a_elig || (!FIXED_PRIORITY && prio));
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign busy = (state != IDLE);

  // Datapath. ram_address / ram_data_in double as the latched request fields,
  // so they hold the granted values through ISSUE and CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio             <= 1'b0;
      lat_id           <= 1'b0;
      lat_we           <= 1'b0;
      a_done           <= 1'b0;
      b_done           <= 1'b0;
      a_rdata          <= 8'h00;
      b_rdata          <= 8'h00;
      ram_address      <= 8'h00;
      ram_data_in      <= 8'h00;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            lat_id           <= grant_b;
            lat_we           <= grant_b ? b_we : a_we;
            ram_address      <= grant_b ? b_addr : a_addr;
            ram_data_in      <= grant_b ? b_wdata : a_wdata;
            ram_write_enable <= grant_b ? b_we : a_we;
            ram_read_enable  <= grant_b ? !b_we : !a_we;
            // Pointer moves to the other port after every grant; in fixed
            // mode it is simply never consulted.
            prio             <= !grant_b;
          end
        end
        ISSUE: begin
          ram_write_enable <= 1'b0;
          ram_read_enable  <= 1'b0;
        end
        CAPTURE: begin
          if (lat_id) begin
            b_done <= 1'b1;
            if (!lat_we) b_rdata <= ram_data_out;
          end else begin
            a_done <= 1'b1;
            if (!lat_we) a_rdata <= ram_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_boruss_ram_arbiter
//
// Directed bench for boruss_ram_arbiter. Two instances share clk/reset: u_rr
// (round-robin) and u_fp (FIXED_PRIORITY=1), each with its own RAM model.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_boruss_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_done, b_done;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] ram_address, ram_data_in, ram_data_out;
  logic       ram_write_enable, ram_read_enable, busy;

  // Fixed-priority instance signals
  logic       f_a_req, f_a_we, f_b_req, f_b_we;
  logic [7:0] f_a_addr, f_a_wdata, f_b_addr, f_b_wdata;
  logic       f_a_done, f_b_done;
  logic [7:0] f_a_rdata, f_b_rdata;
  logic [7:0] f_ram_address, f_ram_data_in, f_ram_data_out;
  logic       f_ram_write_enable, f_ram_read_enable, f_busy;

  boruss_ram_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  boruss_ram_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .a_req(f_a_req), .a_we(f_a_we), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
    .a_done(f_a_done), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_done(f_b_done), .b_rdata(f_b_rdata),
    .ram_address(f_ram_address), .ram_data_in(f_ram_data_in),
    .ram_write_enable(f_ram_write_enable), .ram_read_enable(f_ram_read_enable),
    .ram_data_out(f_ram_data_out), .busy(f_busy)
  );

  // Synchronous RAM models: write on strobe, read data one cycle after strobe
  logic [7:0] mem   [256];
  logic [7:0] f_mem [256];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    if (ram_read_enable)  ram_data_out     <= mem[ram_address];
    if (f_ram_write_enable) f_mem[f_ram_address] <= f_ram_data_in;
    if (f_ram_read_enable)  f_ram_data_out       <= f_mem[f_ram_address];
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int strobe_viol  = 0;   // written only by the monitor below
  int dual_done    = 0;   // written only by the monitor below

  // Every-cycle invariants: strobes exclusive, strobes only while busy, and
  // never both dones at once.
  always @(negedge clk) begin
    if ((ram_write_enable && ram_read_enable) ||
        ((ram_write_enable || ram_read_enable) && !busy)) strobe_viol++;
    if ((f_ram_write_enable && f_ram_read_enable) ||
        ((f_ram_write_enable || f_ram_read_enable) && !f_busy)) strobe_viol++;
    if ((a_done && b_done) || (f_a_done && f_b_done)) dual_done++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_write(input logic [7:0] addr, input logic [7:0] data);
    a_we = 1'b1; a_addr = addr; a_wdata = data; a_req = 1'b1;
    step(3); a_req = 1'b0; step();
  endtask

  task automatic b_write(input logic [7:0] addr, input logic [7:0] data);
    b_we = 1'b1; b_addr = addr; b_wdata = data; b_req = 1'b1;
    step(3); b_req = 1'b0; step();
  endtask

  task automatic f_a_write(input logic [7:0] addr, input logic [7:0] data);
    f_a_we = 1'b1; f_a_addr = addr; f_a_wdata = data; f_a_req = 1'b1;
    step(3); f_a_req = 1'b0; step();
  endtask

  task automatic f_b_write(input logic [7:0] addr, input logic [7:0] data);
    f_b_we = 1'b1; f_b_addr = addr; f_b_wdata = data; f_b_req = 1'b1;
    step(3); f_b_req = 1'b0; step();
  endtask

  // Reset drives every output to zero and blocks arbitration while high.
  task automatic test_reset;
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'hFF; a_wdata = 8'hFF;
    step(2);
    tests_run++;
    if ({a_done, b_done, a_rdata, b_rdata, ram_address, ram_data_in,
         ram_write_enable, ram_read_enable, busy} !== 37'd0) begin
      tests_failed++;
      $display("FAIL reset_rr: got %h want 0", {a_done, b_done, a_rdata, b_rdata,
               ram_address, ram_data_in, ram_write_enable, ram_read_enable, busy});
    end
    tests_run++;
    if ({f_a_done, f_b_done, f_a_rdata, f_b_rdata, f_ram_address, f_ram_data_in,
         f_ram_write_enable, f_ram_read_enable, f_busy} !== 37'd0) begin
      tests_failed++;
      $display("FAIL reset_fp: got %h want 0", {f_a_done, f_b_done, f_a_rdata,
               f_b_rdata, f_ram_address, f_ram_data_in, f_ram_write_enable,
               f_ram_read_enable, f_busy});
    end
    a_req = 1'b0;
    reset = 1'b0;
    step();
  endtask

  // A writes 5A to 10 then reads it back; checks per-cycle latency.
  task automatic test_write_read;
    a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h5A; a_req = 1'b1;
    step();
    tests_run++;
    if ({ram_write_enable, ram_read_enable, ram_address, ram_data_in, busy} !==
        {1'b1, 1'b0, 8'h10, 8'h5A, 1'b1}) begin
      tests_failed++;
      $display("FAIL wr_issue: got we=%b re=%b addr=%h din=%h busy=%b want 1 0 10 5a 1",
               ram_write_enable, ram_read_enable, ram_address, ram_data_in, busy);
    end
    step();
    tests_run++;
    if ({ram_write_enable, ram_read_enable, ram_address, a_done, busy} !==
        {1'b0, 1'b0, 8'h10, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL wr_capture: got we=%b re=%b addr=%h done=%b busy=%b want 0 0 10 0 1",
               ram_write_enable, ram_read_enable, ram_address, a_done, busy);
    end
    step();
    tests_run++;
    if ({a_done, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL wr_done: got done=%b busy=%b want 1 0", a_done, busy);
    end
    tests_run++;
    if (mem[8'h10] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL wr_mem: got %h want 5a", mem[8'h10]);
    end
    a_req = 1'b0;
    step();
    a_we = 1'b0; a_req = 1'b1;
    step();
    tests_run++;
    if ({ram_write_enable, ram_read_enable, ram_address} !== {1'b0, 1'b1, 8'h10}) begin
      tests_failed++;
      $display("FAIL rd_issue: got we=%b re=%b addr=%h want 0 1 10",
               ram_write_enable, ram_read_enable, ram_address);
    end
    step(2);
    tests_run++;
    if ({a_done, a_rdata} !== {1'b1, 8'h5A}) begin
      tests_failed++;
      $display("FAIL rd_done: got done=%b rdata=%h want 1 5a", a_done, a_rdata);
    end
    a_req = 1'b0;
    step();
    tests_run++;
    if ({b_done, b_rdata, a_done} !== 10'd0) begin
      tests_failed++;
      $display("FAIL wr_rd_b_quiet: got b_done=%b b_rdata=%h a_done=%b want 0 00 0",
               b_done, b_rdata, a_done);
    end
  endtask

  // A keeps req high during its done cycle: it must not be served again.
  task automatic test_held_mask;
    a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'h33; a_req = 1'b1;
    step(3);
    tests_run++;
    if ({a_done, a_rdata} !== {1'b1, 8'h5A}) begin
      tests_failed++;
      $display("FAIL hold_wr_done: got done=%b rdata=%h want 1 5a", a_done, a_rdata);
    end
    step();
    tests_run++;
    if ({busy, a_done, ram_write_enable} !== 3'b000) begin
      tests_failed++;
      $display("FAIL hold_no_dup: got busy=%b done=%b we=%b want 0 0 0",
               busy, a_done, ram_write_enable);
    end
    a_req = 1'b0; a_we = 1'b0;
    step();
    a_req = 1'b1;
    step(3);
    tests_run++;
    if ({a_done, a_rdata} !== {1'b1, 8'h33}) begin
      tests_failed++;
      $display("FAIL hold_new_rd: got done=%b rdata=%h want 1 33", a_done, a_rdata);
    end
    a_req = 1'b0;
    step();
  endtask

  // Both ports read with reqs held: A, B, A, B at cycles 3, 6, 9, 12.
  task automatic test_round_robin;
    int n = 0;
    int ord [4];
    int at  [4];
    a_write(8'h01, 8'h11);
    b_write(8'h02, 8'h22);   // last grant was B, so A wins the next contention
    a_we = 1'b0; a_addr = 8'h01; b_we = 1'b0; b_addr = 8'h02;
    a_req = 1'b1; b_req = 1'b1;
    for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
      step();
      if (a_done || b_done) begin
        ord[n] = b_done ? 1 : 0;
        at[n]  = cyc;
        n++;
        if (n == 4) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d dones want 4 (timeout)", n);
      a_req = 1'b0; b_req = 1'b0;
    end else begin
      tests_run++;
      if ({ord[0], ord[1], ord[2], ord[3]} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
        tests_failed++;
        $display("FAIL rr_order: got %0d %0d %0d %0d want 0 1 0 1 (0=A)",
                 ord[0], ord[1], ord[2], ord[3]);
      end
      tests_run++;
      if ({at[0], at[1], at[2], at[3]} !== {32'd3, 32'd6, 32'd9, 32'd12}) begin
        tests_failed++;
        $display("FAIL rr_timing: got %0d %0d %0d %0d want 3 6 9 12",
                 at[0], at[1], at[2], at[3]);
      end
    end
    tests_run++;
    if ({a_rdata, b_rdata} !== {8'h11, 8'h22}) begin
      tests_failed++;
      $display("FAIL rr_data: got a=%h b=%h want 11 22", a_rdata, b_rdata);
    end
    step();
  endtask

  // Fixed priority: A served alone, then A wins the contention that a
  // round-robin arbiter would give to B. B is served only after that.
  task automatic test_fixed_priority;
    int a_seen = 0;
    int b_at   = 0;
    f_a_write(8'h01, 8'h11);
    f_b_write(8'h02, 8'h22);
    f_a_we = 1'b0; f_a_addr = 8'h01; f_b_we = 1'b0; f_b_addr = 8'h02;
    f_a_req = 1'b1;
    step(3);
    tests_run++;
    if ({f_a_done, f_a_rdata} !== {1'b1, 8'h11}) begin
      tests_failed++;
      $display("FAIL fp_first: got done=%b rdata=%h want 1 11", f_a_done, f_a_rdata);
    end
    a_seen = 1;
    f_a_req = 1'b0;
    step();
    f_a_req = 1'b1; f_b_req = 1'b1;
    for (int cyc = 1; cyc <= 12 && b_at == 0; cyc++) begin
      step();
      if (f_a_done) begin a_seen++; f_a_req = 1'b0; end
      if (f_b_done) begin b_at = cyc; f_b_req = 1'b0; end
    end
    f_a_req = 1'b0; f_b_req = 1'b0;
    tests_run++;
    if ({a_seen, b_at} !== {32'd2, 32'd6}) begin
      tests_failed++;
      $display("FAIL fp_order: got a_served=%0d b_done_cycle=%0d want 2 6", a_seen, b_at);
    end
    tests_run++;
    if ({f_a_rdata, f_b_rdata} !== {8'h11, 8'h22}) begin
      tests_failed++;
      $display("FAIL fp_data: got a=%h b=%h want 11 22", f_a_rdata, f_b_rdata);
    end
    step();
  endtask

  // Reset during CAPTURE of a B read aborts it; first cycle after release
  // arbitrates, and A wins contention from the reset pointer.
  task automatic test_reset_mid_op;
    b_we = 1'b0; b_addr = 8'h02; b_req = 1'b1;
    step();
    tests_run++;
    if (ram_read_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_issue: got re=%b want 1", ram_read_enable);
    end
    step();
    reset = 1'b1; b_req = 1'b0;
    step();
    tests_run++;
    if ({a_done, b_done, a_rdata, b_rdata, ram_address, ram_data_in,
         ram_write_enable, ram_read_enable, busy} !== 37'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got done=%b%b rdata=%h/%h addr=%h din=%h we=%b re=%b busy=%b want all 0",
               a_done, b_done, a_rdata, b_rdata, ram_address, ram_data_in,
               ram_write_enable, ram_read_enable, busy);
    end
    reset = 1'b0;
    a_we = 1'b0; a_addr = 8'h01; a_req = 1'b1; b_req = 1'b1;
    step(3);
    tests_run++;
    if ({a_done, b_done, a_rdata} !== {1'b1, 1'b0, 8'h11}) begin
      tests_failed++;
      $display("FAIL rst_after: got a_done=%b b_done=%b a_rdata=%h want 1 0 11",
               a_done, b_done, a_rdata);
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
    tests_run++;
    if ({busy, b_done, b_rdata} !== 10'd0) begin
      tests_failed++;
      $display("FAIL rst_after_quiet: got busy=%b b_done=%b b_rdata=%h want 0 0 00",
               busy, b_done, b_rdata);
    end
  endtask

  task automatic test_invariants;
    tests_run++;
    if (strobe_viol != 0) begin
      tests_failed++;
      $display("FAIL strobe_excl: got %0d violating cycles want 0", strobe_viol);
    end
    tests_run++;
    if (dual_done != 0) begin
      tests_failed++;
      $display("FAIL dual_done: got %0d cycles with both dones want 0", dual_done);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    f_a_req = 1'b0; f_a_we = 1'b0; f_a_addr = 8'h00; f_a_wdata = 8'h00;
    f_b_req = 1'b0; f_b_we = 1'b0; f_b_addr = 8'h00; f_b_wdata = 8'h00;
    step();
    test_reset();
    test_write_read();
    test_held_mask();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_op();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/boruss_ram_arbiter.md
BORUSS_RAM_ARBITER -- requirements
Module: boruss_ram_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0; 0 = round-robin between ports A and B, 1 = port A always wins on contention.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  port A request; held high until a_done.
REQ-005 a_we  input  1  port A access type: 1 = write, 0 = read; stable while a_req high.
REQ-006 a_addr  input  8  port A RAM address; stable while a_req high.
REQ-007 a_wdata  input  8  port A write data; stable while a_req high.
REQ-008 a_done  output  1  registered one-cycle completion pulse for port A.
REQ-009 a_rdata  output  8  registered port A read data; valid when a_done is high after a read.
REQ-010 b_req, b_we, b_addr[7:0], b_wdata[7:0], b_done, b_rdata[7:0] SHALL be the port B equivalents of REQ-004..REQ-009.
REQ-011 ram_address  output  8  registered RAM address.
REQ-012 ram_data_in  output  8  registered RAM write data.
REQ-013 ram_write_enable  output  1  registered RAM write strobe.
REQ-014 ram_read_enable  output  1  registered RAM read strobe.
REQ-015 ram_data_out  input  8  RAM read data, valid one cycle after a read strobe.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and CAPTURE.
REQ-018 IDLE: if any eligible request is present, the FSM SHALL latch the winner's id, we, addr and wdata and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 A port SHALL be ineligible in any cycle where its own done output is high, so a held req is not re-served.
REQ-020 Contention, round-robin mode: 1-bit pointer prio (reset 0) selects the winner; 0 = A wins, 1 = B wins.
REQ-021 prio update: prio SHALL become 1 after A is granted and 0 after B is granted; a lone requester SHALL always win regardless of prio.
REQ-022 FIXED_PRIORITY=1: A SHALL win every contention; prio SHALL be ignored.
REQ-023 ISSUE: for exactly one cycle, the outputs SHALL be:
  - ram_address and ram_data_in = latched values;
  - ram_write_enable = latched we;
  - ram_read_enable = !latched we.
  The FSM SHALL then go to CAPTURE.
REQ-024 Strobe exclusivity: ram_write_enable and ram_read_enable SHALL never be high in the same cycle, and SHALL both be low outside ISSUE.
REQ-025 CAPTURE: ram_address SHALL hold its value, both strobes SHALL be low, and the FSM SHALL return to IDLE.
REQ-026 CAPTURE, winner outputs: the winner's done SHALL be registered high for the next cycle; on a read, the winner's rdata SHALL be loaded from ram_data_out.
REQ-027 On a write, rdata SHALL be unchanged.
REQ-028 Latency: req first seen in IDLE at cycle N gives:
  - RAM strobe in cycle N+1;
  - RAM data valid in N+2;
  - done/rdata in N+3.
  Back-to-back throughput SHALL be one access per 3 cycles.
REQ-029 The non-winning port's done and rdata SHALL be unaffected by the other port's transfer.
REQ-030 A request that drops before grant SHALL simply be ignored; a request that changes fields after grant SHALL not affect the in-flight access.

Reset
REQ-031 While reset is high, at each posedge the outputs SHALL be set as follows:
  - FSM = IDLE and prio = 0;
  - a_done = b_done = 0 and a_rdata = b_rdata = 8'h00;
  - ram_address = ram_data_in = 8'h00;
  - both strobes and busy = 0.
REQ-032 Reset in ISSUE or CAPTURE SHALL abort the access with no done pulse; a write whose ISSUE edge has already passed remains in RAM.
REQ-033 The first arbitration SHALL occur in the first cycle with reset low.

Verification
REQ-034 Write then read: A writes 8'h5A to 8'h10, then reads 8'h10 -> two a_done pulses, each 3 cycles after acceptance; a_rdata = 8'h5A; B outputs unchanged.
REQ-035 Contention, round-robin: A and B both read at once (A addr 8'h01 holding 8'h11; B addr 8'h02 holding 8'h22), reqs held -> order A, B, A, B; a_rdata = 8'h11; b_rdata = 8'h22; never two dones in one cycle.
REQ-036 Fixed priority: FIXED_PRIORITY=1, A and B both requesting; A drops req after its second done -> A served twice before B is served once.
REQ-037 Held-req masking: A holds a_req for one cycle after a_done -> no duplicate access; next ISSUE follows only a new or still-eligible request.
REQ-038 Strobe check: every cycle in every scenario, ram_write_enable AND ram_read_enable = 0; either strobe high only while busy = 1.
REQ-039 Reset mid-op: reset asserted during CAPTURE of a B read -> no b_done; all outputs at reset values next cycle; after release, a new A request completes normally with prio = 0.
